goldschmidt_issue: RTL and testbench
====================================

Name: goldschmidt_issue

Overview:
- Front-end sequencer for the Goldschmidt divider datapath.
- Accepts a numerator/denominator pair over a valid/ready handshake and holds the operands stable for the full iteration.
- Drives the datapath mode/stage selects, captures the final quotient on the correct cycle and presents it downstream over a second valid/ready handshake.
- Divide-by-zero is short-circuited without running the datapath.

Parameters:
- WIDTH, 29, operand/quotient width; must match the datapath instance.
- CYCLES, 12, datapath cycles per division; even, >= 4.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  upstream offers operands
- in_ready  output  1  block accepts operands this cycle
- num_in  input  WIDTH  numerator, fixed-point datapath format
- den_in  input  WIDTH  denominator, fixed-point datapath format
- mode  output  1  to datapath: 0 = seed with k0, 1 = use fed-back k
- stage  output  1  to datapath: 0 = numerator step, 1 = denominator step
- numerator  output  WIDTH  registered numerator to datapath
- denominator  output  WIDTH  registered denominator to datapath
- core_quotient  input  WIDTH  quotient from datapath
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- quo_out  output  WIDTH  captured quotient
- dz_out  output  1  result came from divide-by-zero
- busy  output  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, count=0, numerator=denominator=quo_out=0, dz_out=0, out_valid=0, mode=0, stage=0, busy=0.
- in_ready is asserted in two cases:
  - state==IDLE;
  - state==HOLD && out_ready (back-to-back accept).
- Accept happens when in_valid && in_ready:
  - Register num_in→numerator and den_in→denominator.
  - Operand registers change only on accept.
- States:
  - IDLE: wait for accept. On accept with den_in!=0, go to RUN with count=0. On accept with den_in==0, go to ZERO.
  - RUN: count increments by 1 each cycle.
    - mode = (count >= 2); stage = count[0].
    - When count==CYCLES-1, capture core_quotient→quo_out, set dz_out=0 and out_valid=1, and go to HOLD.
  - ZERO: one cycle.
    - quo_out = all ones, dz_out = 1, out_valid = 1; next state HOLD.
    - mode = 0, stage = 0.
  - HOLD: out_valid stays 1; quo_out and dz_out are stable.
    - mode = 0, stage = 0.
    - On out_ready without a new accept: out_valid=0, go to IDLE.
    - On out_ready with a simultaneous accept: handshake completes, then go to RUN (count=0) or ZERO per the new den_in. out_valid drops for at least one cycle.
- Outside RUN, mode=0 and stage=0, and the datapath result is ignored.
- Latency:
  - accept → out_valid = CYCLES+1 cycles (first RUN cycle is the cycle after accept).
  - zero-denominator: accept → out_valid = 2 cycles.
- No combinational path from in_valid to any output. in_ready depends combinationally only on state and out_ready.
- The count register is ceil(log2(CYCLES)) bits and never exceeds CYCLES-1 (no wrap).
- in_valid while busy and not in the HOLD+out_ready case: not accepted, no state change. Upstream must hold its data.
- out_ready while out_valid=0: ignored.
- Reset asserted mid-RUN or mid-HOLD: immediate return to reset values. The in-flight result is discarded and no out_valid pulse is produced.
- X on num_in/den_in when not accepting must not propagate into state.

Test Plan:
- Single divide: reset, then num_in=0x0800_0000, den_in=0x0C00_0000, in_valid pulse. Bench core stub drives core_quotient=0x0555_5555 at RUN count 11 → out_valid rises exactly 13 cycles after accept, quo_out=0x0555_5555, dz_out=0. Check the mode/stage sequence (0,0),(0,1),(1,0),(1,1)… over 12 cycles.
- Divide-by-zero: den_in=0, num_in=0x0123_4567 → out_valid 2 cycles after accept, quo_out=0x1FFF_FFFF, dz_out=1, mode/stage stay 0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → quo_out stable and in_ready=0 throughout. Raise out_ready → out_valid falls the next cycle.
- Back-to-back: keep in_valid=1 with a second pair ready while in HOLD with out_ready=1 → second operands accepted the same cycle, next RUN starts the following cycle, two results delivered in order.
- Reset mid-operation: assert reset at RUN count 5 → all outputs zero immediately, no out_valid. A new divide afterwards completes normally.
- Ignored input: pulse in_valid at RUN count 3 with den_in=0 → numerator/denominator unchanged and the original result is delivered.

Source files
------------

// File: rtl/goldschmidt_issue.sv
// ============================================================================
// Module   : goldschmidt_issue
// Purpose  : Front-end sequencer for the Goldschmidt divider datapath
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module goldschmidt_issue #(
    parameter int WIDTH  = 29,
    parameter int CYCLES = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num_in,
    input  logic [WIDTH-1:0] den_in,
    output logic             mode,
    output logic             stage,
    output logic [WIDTH-1:0] numerator,
    output logic [WIDTH-1:0] denominator,
    input  logic [WIDTH-1:0] core_quotient,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo_out,
    output logic             dz_out,
    output logic             busy
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          accept;
    logic          den_zero;

    // in_ready must depend only on state and out_ready, never on in_valid
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign den_zero  = (den_in == '0);
    assign count_inc = count + 1'b1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            numerator   <= '0;
            denominator <= '0;
            quo_out     <= '0;
            dz_out      <= 1'b0;
            out_valid   <= 1'b0;
            mode        <= 1'b0;
            stage       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mode  <= 1'b0;
                    stage <= 1'b0;
                    if (accept) begin
                        numerator   <= num_in;
                        denominator <= den_in;
                        count       <= '0;
                        state       <= den_zero ? ZERO : RUN;
                    end
                end
                RUN: begin
                    if (count == LAST_COUNT) begin
                        quo_out   <= core_quotient;
                        dz_out    <= 1'b0;
                        out_valid <= 1'b1;
                        count     <= '0;
                        mode      <= 1'b0;
                        stage     <= 1'b0;
                        state     <= HOLD;
                    end else begin
                        // Selects are registered, so they track the count being entered
                        count <= count_inc;
                        mode  <= (count_inc >= CW'(2));
                        stage <= count_inc[0];
                    end
                end
                ZERO: begin
                    quo_out   <= '1;
                    dz_out    <= 1'b1;
                    out_valid <= 1'b1;
                    mode      <= 1'b0;
                    stage     <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    mode  <= 1'b0;
                    stage <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            numerator   <= num_in;
                            denominator <= den_in;
                            count       <= '0;
                            state       <= den_zero ? ZERO : RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    out_valid <= 1'b0;
                    mode      <= 1'b0;
                    stage     <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_goldschmidt_issue.sv
// ============================================================================
// Module   : tb_goldschmidt_issue
// Purpose  : Scoreboard bench for goldschmidt_issue with a timed datapath stub
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_goldschmidt_issue;

    localparam int WIDTH  = 29;
    localparam int CYCLES = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] num_in = 'x;
    logic [WIDTH-1:0] den_in = 'x;
    logic             mode;
    logic             stage;
    logic [WIDTH-1:0] numerator;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] core_quotient;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] quo_out;
    logic             dz_out;
    logic             busy;

    goldschmidt_issue #(.WIDTH(WIDTH), .CYCLES(CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .num_in       (num_in),
        .den_in       (den_in),
        .mode         (mode),
        .stage        (stage),
        .numerator    (numerator),
        .denominator  (denominator),
        .core_quotient(core_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .quo_out      (quo_out),
        .dz_out       (dz_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             dz;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] qmodel(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        logic [63:0] t;
        t = {35'd0, n} << 27;
        return WIDTH'(t / {35'd0, d});
    endfunction

    // Datapath stub: the true quotient appears only in the RUN cycle with count == CYCLES-1
    logic             stub_active = 1'b0;
    int               stub_start  = 0;
    logic [WIDTH-1:0] stub_q      = '0;
    assign core_quotient = (stub_active && (cyc - stub_start) == CYCLES) ? stub_q : (stub_q ^ 29'h1);

    logic             prev_valid = 1'b0;
    logic             prev_hs    = 1'b0;
    logic [WIDTH-1:0] prev_quo   = '0;
    int               k;
    logic             in_run;
    exp_t             e;

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            k      = cyc - stub_start;
            in_run = stub_active && (k >= 1) && (k <= CYCLES);
            check("mode",  mode,  in_run ? 64'((k - 1) >= 2) : 64'd0);
            check("stage", stage, in_run ? 64'((k - 1) & 1) : 64'd0);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_valid", 1, 0);
                else                check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end
            if (out_valid && prev_valid && !prev_hs) check("quo_stable", quo_out, prev_quo);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("quo", quo_out, e.q);
                    check("dz",  dz_out,  e.dz);
                end
            end
            if (in_valid && in_ready) begin
                if (den_in == '0) begin
                    sb.push_back('{q: '1, dz: 1'b1, acc: cyc, lat: 2});
                    stub_active = 1'b0;
                end else begin
                    sb.push_back('{q: qmodel(num_in, den_in), dz: 1'b0, acc: cyc, lat: CYCLES + 1});
                    stub_active = 1'b1;
                    stub_start  = cyc;
                    stub_q      = qmodel(num_in, den_in);
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_quo   = quo_out;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        num_in   = n;
        den_in   = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num_in   = 'x;
        den_in   = 'x;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"},   out_valid,   0);
        check({tag, "_quo_out"},     quo_out,     0);
        check({tag, "_dz_out"},      dz_out,      0);
        check({tag, "_numerator"},   numerator,   0);
        check({tag, "_denominator"}, denominator, 0);
        check({tag, "_mode"},        mode,        0);
        check({tag, "_stage"},       stage,       0);
        check({tag, "_busy"},        busy,        0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset_in_ready", in_ready, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single divide, then divide-by-zero, downstream always ready
        out_ready = 1'b1;
        send(29'h0800_0000, 29'h0C00_0000);
        drain();
        send(29'h0123_4567, 29'h0);
        drain();

        // Backpressure for 20 cycles
        out_ready = 1'b0;
        send(29'h0300_0000, 29'h0100_0000);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_valid_fall", out_valid, 0);
        drain();

        // Back-to-back: second pair accepted in the HOLD+out_ready cycle
        out_ready = 1'b0;
        send(29'h0100_0000, 29'h0180_0000);
        wait_valid();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        num_in    = 29'h0700_0000;
        den_in    = 29'h0080_0000;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num_in   = 'x;
        den_in   = 'x;
        @(negedge clk);
        check("b2b_gap", out_valid, 0);
        check("b2b_numerator", numerator, 29'h0700_0000);
        drain();

        // Reset at RUN count 5
        send(29'h0400_0000, 29'h0500_0000);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero("midrun");
        sb.delete();
        stub_active = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send(29'h0A00_0000, 29'h0C00_0000);
        drain();

        // in_valid during RUN count 3 must be ignored
        send(29'h0600_0000, 29'h0900_0000);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        num_in   = 29'h1555_0000;
        den_in   = 29'h0;
        @(negedge clk);
        check("ign_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num_in   = 'x;
        den_in   = 'x;
        check("ign_numerator",   numerator,   29'h0600_0000);
        check("ign_denominator", denominator, 29'h0900_0000);
        drain();

        check("sb_left", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
